// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: writeback source selectors, load funct3 codes
// and the writeback-stage state encoding.
package pipe_pkg;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_WAIT_LD = 2'd2
    } wb_state_e;

endpackage

// File: rtl/load_extract.sv
// Load-data aligner: picks the addressed byte/half/word out of an aligned
// memory word, extends it, and flags misaligned or illegal load encodings.
module load_extract
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'h00;
        case (off)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data     = rdata;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH: begin
                data     = {{(XLEN-16){half_v[15]}}, half_v};
                misalign = off[0];
            end
            F3_LHU: begin
                data     = {{(XLEN-16){1'b0}}, half_v};
                misalign = off[0];
            end
            F3_LW: begin
                data     = rdata;
                misalign = (off != 2'd0);
            end
            // 011, 110, 111 are not loads; treat like a misaligned access.
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with writeback mux and load aligner. Holds one
// instruction, waits for the data-memory response on loads, drives the RF.
module wb_stage
    import pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rd,
    input  logic                 in_we,
    input  logic [1:0]           in_wb_sel,
    input  logic [2:0]           in_funct3,
    input  logic [XLEN-1:0]      in_alu,
    input  logic [XLEN-1:0]      in_pc,
    input  logic                 dm_rvalid,
    input  logic [XLEN-1:0]      dm_rdata,
    output logic                 rf_we,
    output logic [4:0]           rf_wa,
    output logic [XLEN-1:0]      rf_wd,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
    output logic                 ld_misalign,
    output logic [INSTRET_W-1:0] instret,
    output wb_state_e            state
);

    // Handshake: an instruction moves from MEM to WB on a rising edge where
    // in_valid & in_ready; in_valid must hold its fields until that edge,
    // and in_ready may depend combinationally on dm_rvalid.

    wb_state_e state_q, state_d;

    logic [4:0]           held_rd;
    logic                 held_we;
    logic [1:0]           held_wb_sel;
    logic [2:0]           held_funct3;
    logic [XLEN-1:0]      held_alu;
    logic [XLEN-1:0]      held_pc;
    logic [INSTRET_W-1:0] instret_q;

    logic            accept;
    logic            retire;
    logic            is_load;
    logic            bad_load;
    logic [XLEN-1:0] ld_data;
    logic            ld_mis;

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .rdata    (dm_rdata),
        .off      (held_alu[1:0]),
        .funct3   (held_funct3),
        .data     (ld_data),
        .misalign (ld_mis)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = (state_q != ST_WAIT_LD) | dm_rvalid;
        accept   = in_valid & in_ready;
        retire   = (state_q == ST_FULL) | ((state_q == ST_WAIT_LD) & dm_rvalid);
        if (accept)      state_d = (in_wb_sel == WB_LOAD) ? ST_WAIT_LD : ST_FULL;
        else if (retire) state_d = ST_EMPTY;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            held_rd     <= '0;
            held_we     <= 1'b0;
            held_wb_sel <= '0;
            held_funct3 <= '0;
            held_alu    <= '0;
            held_pc     <= '0;
        end else if (accept) begin
            held_rd     <= in_rd;
            held_we     <= in_we;
            held_wb_sel <= in_wb_sel;
            held_funct3 <= in_funct3;
            held_alu    <= in_alu;
            held_pc     <= in_pc;
        end
    end

    // Misalignment is only meaningful for a held load; funct3 is ignored otherwise.
    assign is_load  = (held_wb_sel == WB_LOAD);
    assign bad_load = is_load & ld_mis;

    always_comb begin
        case (held_wb_sel)
            WB_LOAD: rf_wd = ld_data;
            WB_PC4:  rf_wd = held_pc + XLEN'(4);
            default: rf_wd = held_alu;
        endcase
    end

    assign rf_we       = retire & held_we & (held_rd != 5'd0) & ~bad_load;
    assign rf_wa       = held_rd;
    assign ld_misalign = retire & bad_load;

    assign fwd_valid = rf_we;
    assign fwd_rd    = rf_wa;
    assign fwd_data  = rf_wd;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                 instret_q <= '0;
        else if (retire & ~bad_load) instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end

    assign instret = instret_q;
    assign state   = state_q;

endmodule
